// File: rtl/seq_alu.sv
// Handshaked RV32I/M execution unit: class-S ops in 1 cycle, MUL/DIV iteratively in WIDTH cycles.
// Backpressure: result held in DONE until outReady; inReady drops while busy or while a result is stalled.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inputA,
    input  logic [WIDTH-1:0] inputB,
    input  logic [4:0]       opSel,
    input  logic [TAG_W-1:0] inTag,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [TAG_W-1:0] outTag
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLL = 5'd2,  OP_SLT = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4, OP_XOR = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
    localparam logic [4:0] OP_OR = 5'd8,   OP_AND = 5'd9,  OP_MULH = 5'd17, OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_DIV = 5'd20, OP_REM = 5'd22;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_n;

    logic [WIDTH-1:0]   hi, lo, mc, hi_n, lo_n;
    logic [SW-1:0]      cnt;
    logic [2:0]         mop;
    logic               qneg, rneg, bzero;
    logic [TAG_W-1:0]   tag_q;
    logic               accept, is_m, last, a_sgn, b_sgn, ge;
    logic [WIDTH-1:0]   s_res, m_res, a_mag, b_mag;
    logic [SW-1:0]      shamt;
    logic [WIDTH:0]     sum, rsh;
    logic [2*WIDTH-1:0] prod, prod_s;

    assign inReady  = (state == IDLE) || (state == DONE && outReady);
    assign accept   = inValid && inReady;
    assign outValid = (state == DONE);
    assign zero     = (result == '0);
    assign is_m     = (opSel[4:3] == 2'b10);
    assign last     = (cnt == SW'(WIDTH - 1));
    assign shamt    = inputB[SW-1:0];

    assign a_sgn = inputA[WIDTH-1] &&
                   (opSel == OP_MULH || opSel == OP_MULHSU || opSel == OP_DIV || opSel == OP_REM);
    assign b_sgn = inputB[WIDTH-1] && (opSel == OP_MULH || opSel == OP_DIV || opSel == OP_REM);
    assign a_mag = a_sgn ? -inputA : inputA;
    assign b_mag = b_sgn ? -inputB : inputB;

    always_comb begin
        s_res = '0;
        case (opSel)
            OP_ADD:  s_res = inputA + inputB;
            OP_SUB:  s_res = inputA - inputB;
            OP_SLL:  s_res = inputA << shamt;
            OP_SLT:  s_res = {{(WIDTH-1){1'b0}}, ($signed(inputA) < $signed(inputB))};
            OP_SLTU: s_res = {{(WIDTH-1){1'b0}}, (inputA < inputB)};
            OP_XOR:  s_res = inputA ^ inputB;
            OP_SRL:  s_res = inputA >> shamt;
            OP_SRA:  s_res = $signed(inputA) >>> shamt;
            OP_OR:   s_res = inputA | inputB;
            OP_AND:  s_res = inputA & inputB;
            default: s_res = '0;
        endcase
    end

    // hi:lo is the product (mul) or remainder:quotient (div); mc is multiplicand or divisor magnitude.
    always_comb begin
        sum = {1'b0, hi} + (lo[0] ? {1'b0, mc} : '0);
        rsh = {hi, lo[WIDTH-1]};
        ge  = (rsh >= {1'b0, mc});
        if (mop[2]) begin
            hi_n = ge ? (rsh[WIDTH-1:0] - mc) : rsh[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], ge};
        end else begin
            hi_n = sum[WIDTH:1];
            lo_n = {sum[0], lo[WIDTH-1:1]};
        end
    end

    assign prod   = {hi_n, lo_n};
    assign prod_s = qneg ? -prod : prod;

    always_comb begin
        m_res = '0;
        case (mop)
            3'd0:    m_res = prod_s[WIDTH-1:0];
            3'd1,
            3'd2,
            3'd3:    m_res = prod_s[2*WIDTH-1:WIDTH];
            3'd4:    m_res = bzero ? '1 : (qneg ? -lo_n : lo_n);
            3'd5:    m_res = lo_n;
            3'd6:    m_res = rneg ? -hi_n : hi_n;
            default: m_res = hi_n;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = is_m ? BUSY : DONE;
            BUSY: if (last) state_n = DONE;
            DONE: begin
                if (accept)        state_n = is_m ? BUSY : DONE;
                else if (outReady) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi     <= '0;
            lo     <= '0;
            mc     <= '0;
            cnt    <= '0;
            mop    <= '0;
            qneg   <= 1'b0;
            rneg   <= 1'b0;
            bzero  <= 1'b0;
            tag_q  <= '0;
            result <= '0;
            outTag <= '0;
        end else if (accept && is_m) begin
            hi    <= '0;
            lo    <= opSel[2] ? a_mag : b_mag;
            mc    <= opSel[2] ? b_mag : a_mag;
            mop   <= opSel[2:0];
            qneg  <= a_sgn ^ b_sgn;
            rneg  <= a_sgn;
            bzero <= (inputB == '0);
            tag_q <= inTag;
            cnt   <= '0;
        end else if (accept) begin
            result <= s_res;
            outTag <= inTag;
        end else if (state == BUSY) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt + 1'b1;
            if (last) begin
                result <= m_res;
                outTag <= tag_q;
            end
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: stimulus pushes expected results, a negedge monitor pops and compares on each handshake.
module tb_seq_alu;
    localparam logic [4:0] ADD = 5'd0,  SUB = 5'd1,  SLL = 5'd2,  SLT = 5'd3,  SLTU = 5'd4;
    localparam logic [4:0] XOR = 5'd5,  SRL = 5'd6,  SRA = 5'd7,  OR_ = 5'd8,  AND_ = 5'd9;
    localparam logic [4:0] MUL = 5'd16, MULH = 5'd17, MULHSU = 5'd18, MULHU = 5'd19;
    localparam logic [4:0] DIV = 5'd20, DIVU = 5'd21, REM = 5'd22, REMU = 5'd23;

    logic        clk;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [31:0] inputA;
    logic [31:0] inputB;
    logic [4:0]  opSel;
    logic [4:0]  inTag;
    logic        outValid;
    logic        outReady;
    logic [31:0] result;
    logic        zero;
    logic [4:0]  outTag;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   pops  = 0;

    seq_alu #(.WIDTH(32), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
        .inputA(inputA), .inputB(inputB), .opSel(opSel), .inTag(inTag),
        .outValid(outValid), .outReady(outReady), .result(result),
        .zero(zero), .outTag(outTag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %08h, expected %08h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    // Monitor: samples 2 time units after the falling edge, well before the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!reset && outValid && outReady) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got %08h tag %0d, expected no result", result, outTag);
            end else begin
                e = exp_q.pop_front();
                pops++;
                chk32("result", result, e.res);
                chk1("zero", zero, (e.res == 32'd0));
                chk32("tag", 32'(outTag), 32'(e.tag));
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance with inputs scrambled.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] e);
        int   n;
        exp_t x;
        n = 0;
        inValid = 1'b1;
        opSel   = op;
        inputA  = a;
        inputB  = b;
        inTag   = tag;
        while (!inReady && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!inReady) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: op %0d not accepted after %0d cycles", op, n);
        end else begin
            x.res = e;
            x.tag = tag;
            exp_q.push_back(x);
        end
        @(negedge clk);
        inValid = 1'b0;
        inputA  = ~a;
        inputB  = ~b;
        opSel   = op ^ 5'd1;
        inTag   = ~tag;
    endtask

    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [31:0] e, input int lat);
        int n;
        bit rdy_seen;
        issue(op, a, b, tag, e);
        n = 0;
        rdy_seen = 1'b0;
        while (!outValid && n < 100) begin
            if (inReady) rdy_seen = 1'b1;
            @(negedge clk);
            n++;
        end
        chk32("latency_edges", n, lat);
        if (lat > 0) chk1("inready_while_busy", rdy_seen, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        inValid = 1'b0;
        while ((exp_q.size() != 0 || outValid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk32("drain_queue", exp_q.size(), 0);
    endtask

    initial begin
        int p0;
        reset    = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b1;
        inputA   = '0;
        inputB   = '0;
        opSel    = '0;
        inTag    = '0;
        repeat (2) @(negedge clk);
        chk1("rst_valid", outValid, 1'b0);
        chk32("rst_result", result, 32'd0);
        chk1("rst_zero", zero, 1'b1);
        chk32("rst_tag", 32'(outTag), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk1("rst_inready", inReady, 1'b1);

        // class S
        run_op(ADD,  32'h7FFFFFFF, 32'h00000001, 5'd1,  32'h80000000, 0);
        run_op(SUB,  32'd5,        32'd5,        5'd2,  32'h00000000, 0);
        run_op(SRA,  32'h80000000, 32'h00000024, 5'd3,  32'hF8000000, 0);
        run_op(SRL,  32'h80000000, 32'h00000004, 5'd4,  32'h08000000, 0);
        run_op(SLL,  32'h00000001, 32'h00000021, 5'd5,  32'h00000002, 0);
        run_op(SLT,  32'hFFFFFFFF, 32'h00000001, 5'd6,  32'h00000001, 0);
        run_op(SLTU, 32'hFFFFFFFF, 32'h00000001, 5'd7,  32'h00000000, 0);
        run_op(XOR,  32'h0000F0F0, 32'h0000FF00, 5'd8,  32'h00000FF0, 0);
        run_op(OR_,  32'h0000F0F0, 32'h0000FF00, 5'd9,  32'h0000FFF0, 0);
        run_op(AND_, 32'h0000F0F0, 32'h0000FF00, 5'd10, 32'h0000F000, 0);
        run_op(5'd12, 32'h12345678, 32'h11111111, 5'd11, 32'h00000000, 0);
        run_op(5'd27, 32'h12345678, 32'h11111111, 5'd12, 32'h00000000, 0);

        // class M
        run_op(MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'h00000000, 32);
        run_op(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd14, 32'hFFFFFFFF, 32);
        run_op(MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd15, 32'hFFFFFFFE, 32);
        run_op(MUL,    32'hFFFFFFFF, 32'h00000002, 5'd16, 32'hFFFFFFFE, 32);
        run_op(DIVU,   32'd7,        32'd0,        5'd17, 32'hFFFFFFFF, 32);
        run_op(REMU,   32'd7,        32'd0,        5'd18, 32'h00000007, 32);
        run_op(DIV,    32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h80000000, 32);
        run_op(REM,    32'h80000000, 32'hFFFFFFFF, 5'd20, 32'h00000000, 32);
        run_op(DIV,    32'hFFFFFFF9, 32'd2,        5'd21, 32'hFFFFFFFD, 32);
        run_op(REM,    32'hFFFFFFF9, 32'd2,        5'd22, 32'hFFFFFFFF, 32);
        run_op(DIV,    32'd7,        32'd0,        5'd23, 32'hFFFFFFFF, 32);
        run_op(REM,    32'hFFFFFFF9, 32'd0,        5'd24, 32'hFFFFFFF9, 32);
        run_op(DIVU,   32'd100,      32'd7,        5'd25, 32'd14,       32);
        drain();

        // backpressure on a completed MUL, then simultaneous release and new ADD
        outReady = 1'b0;
        run_op(MUL, 32'd6, 32'd7, 5'd9, 32'd42, 32);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("bp_valid", outValid, 1'b1);
            chk32("bp_result", result, 32'd42);
            chk32("bp_tag", 32'(outTag), 32'd9);
            chk1("bp_inready", inReady, 1'b0);
        end
        outReady = 1'b1;
        #1;
        chk1("bp_release_inready", inReady, 1'b1);
        issue(ADD, 32'd10, 32'd20, 5'd3, 32'd30);
        chk1("bp_add_valid", outValid, 1'b1);
        chk32("bp_add_tag", 32'(outTag), 32'd3);
        drain();

        // back-to-back class S
        p0 = pops;
        for (int i = 0; i < 4; i++) begin
            issue(ADD, 32'(i * 100), 32'd1, 5'(4 + i), 32'(i * 100 + 1));
            chk1("b2b_valid", outValid, 1'b1);
        end
        drain();
        chk32("b2b_count", pops, p0 + 4);

        // reset in the middle of a DIV; an inValid during reset must be ignored
        issue(DIV, 32'd100, 32'd7, 5'd8, 32'd14);
        repeat (10) @(negedge clk);
        void'(exp_q.pop_back());
        reset   = 1'b1;
        inValid = 1'b1;
        opSel   = ADD;
        inputA  = 32'd1;
        inputB  = 32'd1;
        inTag   = 5'd2;
        @(negedge clk);
        reset   = 1'b0;
        inValid = 1'b0;
        chk1("midrst_valid", outValid, 1'b0);
        chk32("midrst_result", result, 32'd0);
        chk1("midrst_zero", zero, 1'b1);
        chk32("midrst_tag", 32'(outTag), 32'd0);
        chk1("midrst_inready", inReady, 1'b1);
        @(negedge clk);
        chk1("midrst_ignored_req", outValid, 1'b0);
        run_op(ADD, 32'd2, 32'd3, 5'd1, 32'd5, 0);
        repeat (40) @(negedge clk);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked execution unit for the RISC-V core. It extends the base integer ALU operations with the RV32M multiply/divide set, which runs on an iterative datapath. Single-cycle ops return one cycle after acceptance. Multiply/divide ops return after a fixed WIDTH-cycle latency. An opaque tag travels with each operation so the issue stage can match results to destinations.

## Interface
- WIDTH, 32: operand/result width; power of two, 8..64.
- TAG_W, 5: width of the pass-through tag (destination register index).
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- inValid  in  1  operation request valid.
- inReady  out  1  unit can accept a request this cycle.
- inputA  in  WIDTH  operand A (rs1).
- inputB  in  WIDTH  operand B (rs2).
- opSel  in  5  operation code, see Operation.
- inTag  in  TAG_W  tag captured with the request.
- outValid  out  1  result valid.
- outReady  in  1  consumer accepts the result.
- result  out  WIDTH  operation result.
- zero  out  1  result == 0.
- outTag  out  TAG_W  tag of the operation in result.

## Operation
- Opcodes, single-cycle (class S):
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 10-15 and 24-31 are unused and produce result 0.
- Opcodes, iterative (class M): 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
- Shift amount is inputB[log2(WIDTH)-1:0]. SRA is arithmetic.
- SLT/SLTU return 1 or 0, zero-extended.
- ADD, SUB and MUL wrap modulo 2^WIDTH.
- MULH* returns the upper WIDTH bits of the 2*WIDTH-bit product. MULHSU treats A as signed and B as unsigned.
- Division rounds toward zero. The remainder takes the dividend's sign.
- Divide by zero:
  - DIV and DIVU return all ones.
  - REM and REMU return inputA.
- Signed overflow (A = most negative, B = -1): DIV returns A, REM returns 0.
- The special cases above still take the full class-M latency.
- Multiply datapath: shift-add, one partial-product bit per iteration. Signed ops are handled by magnitude operation plus final sign correction.
- Divide datapath: restoring, one quotient bit per iteration, same sign handling.
- FSM:
  - IDLE → BUSY on acceptance of a class-M op, with iteration counter = 0.
  - IDLE → DONE on acceptance of a class-S op, with result registered.
  - BUSY: one iteration per cycle. When the counter reaches WIDTH-1, BUSY → DONE.
  - DONE → IDLE on outValid && outReady, unless a new request is accepted in the same cycle.
  - In that case DONE goes directly to BUSY or DONE according to the new op's class.
- inReady = (state == IDLE) || (state == DONE && outReady). This is combinational from outReady.
- Operands, opSel and inTag are captured at acceptance. Later input changes have no effect.
- outValid = (state == DONE).
- result, zero and outTag are stable while outValid && !outReady.

## Timing
- Acceptance: rising edge with inValid && inReady.
- Class S: outValid is high from the first edge after acceptance. Latency is 1.
- Class M: outValid is high from the WIDTH-th edge after acceptance. Latency is WIDTH, e.g. 32 for WIDTH=32.
- Throughput with outReady held high:
  - class S: 1 op per cycle;
  - class M: 1 op per WIDTH cycles.
- Backpressure: DONE holds indefinitely and inReady stays low.
- Reset, including mid-BUSY or mid-DONE:
  - next edge: state = IDLE, outValid = 0, result = 0, zero = 1, outTag = 0, counter = 0;
  - inReady = 1 in the cycle after reset deasserts;
  - an inValid presented while reset is high is ignored.
- An in-flight op is discarded by reset and no result is produced for it.

## Test plan
- ADD/SUB/SRA:
  - ADD 0x7FFFFFFF + 1 → 0x80000000 at latency 1;
  - SUB 5 - 5 → 0, zero = 1;
  - SRA 0x80000000 by 0x24 (shift 4) → 0xF8000000.
- MULH/MULHSU/MULHU with A = 0xFFFFFFFF, B = 0xFFFFFFFF → 0x00000000 / 0xFFFFFFFF / 0xFFFFFFFE. outValid rises exactly 32 edges after acceptance, and inReady stays low while busy.
- Divide corners:
  - DIVU 7/0 → 0xFFFFFFFF;
  - REMU 7/0 → 7;
  - DIV 0x80000000/-1 → 0x80000000;
  - REM 0x80000000/-1 → 0;
  - DIV -7/2 → -3 (0xFFFFFFFD);
  - REM -7/2 → -1.
- Backpressure: hold outReady = 0 for 5 cycles after a MUL completes. result, outTag and outValid stay stable, and inReady = 0. Then raise outReady while presenting an ADD with inTag = 3. Both handshakes happen on the same edge, and the ADD result appears with outTag = 3 one cycle later.
- Back-to-back class S: present 4 ADDs on consecutive cycles with outReady = 1. Four results appear on 4 consecutive cycles, in order, with their tags.
- Reset at BUSY iteration 10 of a DIV:
  - next cycle: outValid = 0, result = 0, inReady = 1;
  - a following ADD 2 + 3 → 5 at latency 1;
  - no stale DIV result ever appears.
